// File: rtl/free_reg_list_pkg.sv
// Shared machine constants for the rename free lists.
package free_reg_list_pkg;

  // Physical register file sizes (list depths must be powers of two).
  localparam int NUM_D_REG    = 32;
  localparam int NUM_S_REG    = 8;

  // Architectural data registers; physical 0..NUM_ARCH_REG-1 hold them at reset.
  localparam int NUM_ARCH_REG = 16;

endpackage

// File: rtl/free_reg_list_if.sv
// Rename/retire side bus of the free register lists.
interface free_reg_list_if
  import free_reg_list_pkg::*;
#(
  parameter int D_DEPTH = NUM_D_REG,
  parameter int S_DEPTH = NUM_S_REG
);
  localparam int DAW = $clog2(D_DEPTH);
  localparam int SAW = $clog2(S_DEPTH);

  // Allocation (rename)
  logic           alloc_valid;
  logic           use_rw;
  logic           use_rs;
  logic [DAW-1:0] rw_addr;
  logic [SAW-1:0] rs_addr;
  logic           stall;

  // Return and commit (retire)
  logic           free_d_valid;
  logic [DAW-1:0] free_d_addr;
  logic           free_s_valid;
  logic [SAW-1:0] free_s_addr;
  logic           commit_rw;
  logic           commit_rs;
  logic           flush;

  // Status
  logic [DAW:0]   d_count;
  logic [SAW:0]   s_count;
  logic           overflow_err;

  modport master (
    output alloc_valid, use_rw, use_rs,
    output free_d_valid, free_d_addr, free_s_valid, free_s_addr,
    output commit_rw, commit_rs, flush,
    input  rw_addr, rs_addr, stall, d_count, s_count, overflow_err
  );

  modport slave (
    input  alloc_valid, use_rw, use_rs,
    input  free_d_valid, free_d_addr, free_s_valid, free_s_addr,
    input  commit_rw, commit_rs, flush,
    output rw_addr, rs_addr, stall, d_count, s_count, overflow_err
  );

endinterface

// File: rtl/free_reg_list_fifo.sv
// One free list: circular buffer with speculative head, commit head and tail.
// Pointers carry one extra wrap bit so tail - head distinguishes full from empty;
// DEPTH must be a power of two so the low bits index the buffer directly.
module frl_fifo #(
  parameter  int DEPTH    = 32,
  parameter  int RST_BASE = 16,
  parameter  int RST_FILL = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  input  logic          free_valid_i,
  input  logic [AW-1:0] free_addr_i,
  input  logic          commit_i,
  input  logic          flush_i,
  output logic [AW-1:0] head_addr_o,
  output logic [PW-1:0] count_o,
  output logic          overflow_o
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] chead_q, chead_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          ovf_q, ovf_d;
  logic          commit_ok;
  logic          push_ok;

  // Entries still free counts from the speculative head, not the commit head.
  assign count_o     = tail_q - head_q;
  assign head_addr_o = mem_q[head_q[AW-1:0]];
  assign overflow_o  = ovf_q;

  // Pointer next-state: commit may not overtake head, full lists drop pushes,
  // and flush rewinds head to the commit head including this cycle's commit.
  always_comb begin
    commit_ok = commit_i && (chead_q != head_q);
    push_ok   = free_valid_i && (count_o != PW'(DEPTH));
    chead_d   = chead_q + PW'(commit_ok);
    tail_d    = tail_q + PW'(push_ok);
    head_d    = head_q;
    if (flush_i) begin
      head_d = chead_d;
    end else if (alloc_i) begin
      head_d = head_q + PW'(1);
    end
    ovf_d = ovf_q | (commit_i & ~commit_ok) | (free_valid_i & ~push_ok);
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PW'(RST_FILL);
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
    end
  end

  // List storage: reset preloads the free registers, returns write at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < RST_FILL) ? AW'(RST_BASE + i) : '0;
      end
    end else if (push_ok) begin
      mem_q[tail_q[AW-1:0]] <= free_addr_i;
    end
  end

endmodule

// File: rtl/free_reg_list.sv
// Free physical register lists for data (D) and status (S) registers.
module free_reg_list
  import free_reg_list_pkg::*;
#(
  parameter int D_DEPTH = NUM_D_REG,
  parameter int S_DEPTH = NUM_S_REG
) (
  input logic            clk,
  input logic            rst,
  free_reg_list_if.slave frl
);

  logic alloc_go;
  logic d_ovf, s_ovf;

  // An allocation needs every list it uses to be non-empty; otherwise nothing moves.
  assign frl.stall = frl.alloc_valid &
                     ((frl.use_rw & (frl.d_count == '0)) |
                      (frl.use_rs & (frl.s_count == '0)));
  assign alloc_go  = frl.alloc_valid & ~frl.stall & ~frl.flush;

  assign frl.overflow_err = d_ovf | s_ovf;

  frl_fifo #(
    .DEPTH    (D_DEPTH),
    .RST_BASE (NUM_ARCH_REG),
    .RST_FILL (D_DEPTH - NUM_ARCH_REG)
  ) u_d_list (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (alloc_go & frl.use_rw),
    .free_valid_i (frl.free_d_valid),
    .free_addr_i  (frl.free_d_addr),
    .commit_i     (frl.commit_rw),
    .flush_i      (frl.flush),
    .head_addr_o  (frl.rw_addr),
    .count_o      (frl.d_count),
    .overflow_o   (d_ovf)
  );

  // Physical status register 0 holds the architectural status at reset.
  frl_fifo #(
    .DEPTH    (S_DEPTH),
    .RST_BASE (1),
    .RST_FILL (S_DEPTH - 1)
  ) u_s_list (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (alloc_go & frl.use_rs),
    .free_valid_i (frl.free_s_valid),
    .free_addr_i  (frl.free_s_addr),
    .commit_i     (frl.commit_rs),
    .flush_i      (frl.flush),
    .head_addr_o  (frl.rs_addr),
    .count_o      (frl.s_count),
    .overflow_o   (s_ovf)
  );

endmodule

// File: tb/tb_free_reg_list.sv
module tb_free_reg_list;

  localparam int DD = 32;
  localparam int SD = 8;
  localparam int X  = -1;  // don't-care marker in expectation records

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  free_reg_list_if #(.D_DEPTH(DD), .S_DEPTH(SD)) bus ();

  free_reg_list #(.D_DEPTH(DD), .S_DEPTH(SD)) dut (
    .clk (clk),
    .rst (rst),
    .frl (bus)
  );

  typedef struct {
    string name;
    int    rw;
    int    rs;
    int    dc;
    int    sc;
    int    st;
    int    ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    if (req >= 0) begin
      n_tests++;
      if (act != req) begin
        n_fail++;
        $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      end
    end
  endtask

  // Monitor: on each falling edge compare DUT outputs against queued expectations.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "rw_addr",      int'(bus.rw_addr),      e.rw);
        chk(e.name, "rs_addr",      int'(bus.rs_addr),      e.rs);
        chk(e.name, "d_count",      int'(bus.d_count),      e.dc);
        chk(e.name, "s_count",      int'(bus.s_count),      e.sc);
        chk(e.name, "stall",        int'(bus.stall),        e.st);
        chk(e.name, "overflow_err", int'(bus.overflow_err), e.ov);
      end
    end
  end

  task automatic exp_push(input string nm, input int rw, input int rs, input int dc,
                          input int sc, input int st, input int ov);
    sb_q.push_back('{nm, rw, rs, dc, sc, st, ov});
  endtask

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.use_rw       = 1'b0;
    bus.use_rs       = 1'b0;
    bus.free_d_valid = 1'b0;
    bus.free_d_addr  = '0;
    bus.free_s_valid = 1'b0;
    bus.free_s_addr  = '0;
    bus.commit_rw    = 1'b0;
    bus.commit_rs    = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    exp_push("reset", 16, 1, 16, 7, 0, 0);
    tick();

    // Drain the D list in order
    for (int i = 0; i < 16; i++) begin
      bus.alloc_valid = 1'b1;
      bus.use_rw      = 1'b1;
      exp_push("alloc_rw", 16 + i, X, 16 - i, 7, 0, X);
      tick();
    end
    exp_push("alloc_empty", X, X, 0, 7, 1, X);
    tick();
    exp_push("stall_hold", X, X, 0, 7, 1, 0);
    tick();

    // Free into empty list with same-cycle alloc: no bypass
    bus.free_d_valid = 1'b1;
    bus.free_d_addr  = 5'd5;
    exp_push("free_alloc_empty", X, X, 0, 7, 1, X);
    tick();
    idle();
    exp_push("free_visible", 5, X, 1, 7, 0, 0);
    tick();

    // 4 allocs, 2 commits, flush
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.alloc_valid = 1'b1;
      bus.use_rw      = 1'b1;
      exp_push("alloc4", 16 + i, X, 16 - i, 7, 0, 0);
      tick();
    end
    idle();
    bus.commit_rw = 1'b1;
    exp_push("commit1", 20, X, 12, 7, 0, 0);
    tick();
    exp_push("commit2", 20, X, 12, 7, 0, 0);
    tick();
    idle();
    bus.flush = 1'b1;
    exp_push("flush_cyc", 20, X, 12, 7, 0, 0);
    tick();
    idle();
    exp_push("after_flush", 18, X, 14, 7, 0, 0);
    tick();

    // Commit with commit_head == head is ignored and flagged
    bus.commit_rw = 1'b1;
    exp_push("commit_at_head", 18, X, 14, 7, 0, 0);
    tick();
    idle();
    exp_push("commit_at_head_err", 18, X, 14, 7, 0, 1);
    tick();

    // Atomicity with an empty S list
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.alloc_valid = 1'b1;
      bus.use_rs      = 1'b1;
      exp_push("alloc_rs", 16, 1 + i, 16, 7 - i, 0, 0);
      tick();
    end
    bus.use_rw = 1'b1;
    exp_push("atomic_stall", 16, X, 16, 0, 1, X);
    tick();
    exp_push("atomic_hold", 16, X, 16, 0, 1, 0);
    tick();
    bus.free_s_valid = 1'b1;
    bus.free_s_addr  = 3'd3;
    exp_push("s_free_same", 16, X, 16, 0, 1, X);
    tick();
    bus.free_s_valid = 1'b0;
    exp_push("s_free_clears", 16, 3, 16, 1, 0, 0);
    tick();
    idle();
    exp_push("both_alloc", 17, X, 15, 0, 0, 0);
    tick();

    // Push on a full D list
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.free_d_valid = 1'b1;
      bus.free_d_addr  = 5'(i);
      exp_push("fill", 16, X, 16 + i, 7, 0, 0);
      tick();
    end
    bus.free_d_addr = 5'd9;
    exp_push("push_full", 16, X, 32, 7, 0, 0);
    tick();
    idle();
    exp_push("ovf_set", 16, X, 32, 7, 0, 1);
    tick();
    bus.alloc_valid = 1'b1;
    bus.use_rw      = 1'b1;
    exp_push("alloc_after_ovf", 16, X, 32, 7, 0, 1);
    tick();
    idle();
    exp_push("ovf_sticky", 17, X, 31, 7, 0, 1);
    tick();
    do_reset();
    exp_push("ovf_cleared", 16, 1, 16, 7, 0, 0);
    tick();

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/free_reg_list.md
FREE_REG_LIST -- requirements
Module: free_reg_list

Interface
REQ-001 Parameters: D_DEPTH, default `NUM_D_REG, physical data registers; S_DEPTH, default `NUM_S_REG, physical status registers.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 alloc_valid  in  1  rename slot valid this cycle.
REQ-006 use_rw  in  1  renamed instruction writes a data register.
REQ-007 use_rs  in  1  renamed instruction writes the status register.
REQ-008 rw_addr  out  clog2(D_DEPTH)  next free physical data register (head of D list).
REQ-009 rs_addr  out  clog2(S_DEPTH)  next free physical status register (head of S list).
REQ-010 stall  out  1  allocation cannot complete this cycle.
REQ-011 free_d_valid / free_d_addr  in  1 / clog2(D_DEPTH)  return physical data register at retire.
REQ-012 free_s_valid / free_s_addr  in  1 / clog2(S_DEPTH)  return physical status register at retire.
REQ-013 commit_rw / commit_rs  in  1 / 1  retiring instruction had allocated rw / rs.
REQ-014 flush  in  1  squash all uncommitted allocations.
REQ-015 d_count / s_count  out  clog2(D_DEPTH)+1 / clog2(S_DEPTH)+1  free entries available.
REQ-016 overflow_err  out  1  sticky; push attempted on full list.

Function
REQ-017 Each list SHALL be a circular buffer of DEPTH entries with head (speculative alloc), commit_head, tail pointers, each clog2(DEPTH)+1 bits, wrap-around via modulo-DEPTH indexing.
REQ-018 rw_addr/rs_addr SHALL be combinational reads of mem[head]; the consumer latches them at the same edge the head advances (zero-cycle latency).
REQ-019 stall SHALL equal alloc_valid & ((use_rw & d_count==0) | (use_rs & s_count==0)).
REQ-020 Allocation SHALL be atomic: when alloc_valid & ~stall & ~flush, D head increments if use_rw and S head increments if use_rs; when stalled neither head moves.
REQ-021 free_*_valid SHALL write free_*_addr at mem[tail] and increment tail; if count==DEPTH the write is dropped and overflow_err sets.
REQ-022 commit_rw/commit_rs SHALL increment the corresponding commit_head by one.
REQ-023 flush SHALL set head to the commit_head value after this cycle's commit; flush overrides allocation in the same cycle.
REQ-024 Free and allocation in the same cycle on an empty list: no bypass, allocation stalls, pushed entry becomes visible next cycle.
REQ-025 Free, commit and flush in the same cycle SHALL all take effect; count = tail - head computed from registered pointers.
REQ-026 Commit SHALL never pass head; a commit with commit_head==head is ignored and sets overflow_err.

Reset
REQ-027 On rst, D list entries 0..D_DEPTH-17 SHALL hold 16..D_DEPTH-1 (physical 0..15 hold initial architectural state); head=commit_head=0, tail=D_DEPTH-16.
REQ-028 On rst, S list entries 0..S_DEPTH-2 SHALL hold 1..S_DEPTH-1; head=commit_head=0, tail=S_DEPTH-1.
REQ-029 On rst, overflow_err=0, stall=0; rst mid-operation discards all in-flight allocations and frees; rst overrides every other input.

Structure
REQ-030 `NUM_D_REG, `NUM_S_REG and the architectural register count (16) SHALL come from the shared nand_cpu header/package.
REQ-031 One sub-module, frl_fifo (parameterized depth, reset base value, reset fill count), SHALL implement a list; free_reg_list instantiates two and generates stall.

Verification (D_DEPTH=32, S_DEPTH=8)
REQ-032 Reset -> rw_addr=16, rs_addr=1, d_count=16, s_count=7, stall=0.
REQ-033 16 allocs use_rw=1 -> rw_addr 16..31 in order, d_count=0; 17th alloc -> stall=1, head unchanged.
REQ-034 Empty D list, free_d_addr=5 with alloc same cycle -> stall=1 that cycle; next cycle rw_addr=5, d_count=1.
REQ-035 4 allocs, commit_rw twice, flush -> rw_addr=18, d_count=14.
REQ-036 use_rw=1, use_rs=1, S list empty -> stall=1, D head unchanged (atomicity); s free then clears stall.
REQ-037 Push on full D list (32 entries) -> entry dropped, overflow_err=1 until rst.
